// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the two-road traffic light LED outputs: decodes phases,
// measures phase durations and raises sticky illegal/order/timing errors.
// Optional build macro TRAFFIC_MON_STUCK_DETECT_EN enables the held-pattern (stuck) check.
module traffic_light_monitor #(
    parameter int unsigned T_PH0       = 19,
    parameter int unsigned T_PH1       = 3,
    parameter int unsigned T_PH2       = 29,
    parameter int unsigned T_PH3       = 3,
    parameter int unsigned STUCK_LIMIT = 40
) (
    input  logic       clk1h,
    input  logic       rst_n,
    input  logic [2:0] led1,
    input  logic [2:0] led2,
    input  logic       err_clr,
    output logic [1:0] phase,
    output logic       locked,
    output logic [5:0] dur_cnt,
    output logic [5:0] last_dur,
    output logic [7:0] cycle_cnt,
    output logic       err_illegal,
    output logic       err_order,
    output logic       err_timing,
    output logic       err_stuck
);

    typedef enum logic [1:0] {
        S_SYNC,
        S_ACQ,
        S_TRACK
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_phase, w_phase_nxt;
    logic [5:0] r_dur_cnt, w_dur_nxt;
    logic [5:0] r_last_dur, w_last_dur_nxt;
    logic [7:0] r_cycle_cnt, w_cycle_nxt;
    logic       r_err_illegal, r_err_order, r_err_timing;
    logic       w_set_illegal, w_set_order, w_set_timing;
    logic       w_legal;
    logic [1:0] w_ph;
    logic [1:0] w_ph_succ;
    logic [5:0] w_dur_inc;

    function automatic logic [5:0] exp_dur(input logic [1:0] ph);
        case (ph)
            2'd0:    exp_dur = 6'(T_PH0);
            2'd1:    exp_dur = 6'(T_PH1);
            2'd2:    exp_dur = 6'(T_PH2);
            default: exp_dur = 6'(T_PH3);
        endcase
    endfunction

    always_comb begin
        w_legal = 1'b1;
        w_ph    = 2'd0;
        case ({led1, led2})
            6'b100_001: w_ph = 2'd0;
            6'b100_010: w_ph = 2'd1;
            6'b001_100: w_ph = 2'd2;
            6'b010_100: w_ph = 2'd3;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_ph_succ = r_phase + 2'd1;
    assign w_dur_inc = (r_dur_cnt == 6'd63) ? 6'd63 : r_dur_cnt + 6'd1;

    // SYNC is exactly the "no previous pattern" condition, so r_phase doubles as prev otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_dur_nxt      = r_dur_cnt;
        w_last_dur_nxt = r_last_dur;
        w_cycle_nxt    = r_cycle_cnt;
        w_set_illegal  = 1'b0;
        w_set_order    = 1'b0;
        w_set_timing   = 1'b0;
        if (!w_legal) begin
            w_set_illegal = 1'b1;
            w_state_nxt   = S_SYNC;
            w_dur_nxt     = '0;
        end else if (r_state == S_SYNC) begin
            w_state_nxt    = S_ACQ;
            w_dur_nxt      = 6'd1;
            w_last_dur_nxt = r_dur_cnt;
            w_phase_nxt    = w_ph;
        end else if (w_ph == r_phase) begin
            w_dur_nxt = w_dur_inc;
        end else begin
            w_last_dur_nxt = r_dur_cnt;
            w_dur_nxt      = 6'd1;
            w_phase_nxt    = w_ph;
            if (r_state == S_ACQ) begin
                if (w_ph == w_ph_succ) w_state_nxt = S_TRACK;
            end else begin
                w_set_order  = (w_ph != w_ph_succ);
                w_set_timing = (r_dur_cnt != exp_dur(r_phase));
                if (r_phase == 2'd3 && w_ph == 2'd0) w_cycle_nxt = r_cycle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk1h) begin
        if (!rst_n) begin
            r_state       <= S_SYNC;
            r_phase       <= '0;
            r_dur_cnt     <= '0;
            r_last_dur    <= '0;
            r_cycle_cnt   <= '0;
            r_err_illegal <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_timing  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_dur_cnt     <= w_dur_nxt;
            r_last_dur    <= w_last_dur_nxt;
            r_cycle_cnt   <= w_cycle_nxt;
            // A new error in the same cycle as err_clr wins.
            r_err_illegal <= (r_err_illegal & ~err_clr) | w_set_illegal;
            r_err_order   <= (r_err_order   & ~err_clr) | w_set_order;
            r_err_timing  <= (r_err_timing  & ~err_clr) | w_set_timing;
        end
    end

`ifdef TRAFFIC_MON_STUCK_DETECT_EN
    logic r_err_stuck;
    logic w_set_stuck;

    always_comb begin
        w_set_stuck = 1'b0;
        if (w_legal && r_state != S_SYNC && w_ph == r_phase &&
            w_dur_inc != r_dur_cnt && 32'(w_dur_inc) == STUCK_LIMIT)
            w_set_stuck = 1'b1;
    end

    always_ff @(posedge clk1h) begin
        if (!rst_n) r_err_stuck <= 1'b0;
        else        r_err_stuck <= (r_err_stuck & ~err_clr) | w_set_stuck;
    end

    assign err_stuck = r_err_stuck;
`else
    assign err_stuck = 1'b0;
`endif

    assign phase       = r_phase;
    assign locked      = (r_state == S_TRACK);
    assign dur_cnt     = r_dur_cnt;
    assign last_dur    = r_last_dur;
    assign cycle_cnt   = r_cycle_cnt;
    assign err_illegal = r_err_illegal;
    assign err_order   = r_err_order;
    assign err_timing  = r_err_timing;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the led1/led2 outputs of the two-road traffic light controller; the "receiver" end of that LED interface.
- Decodes the LED patterns back into phase codes and measures how many clk1h ticks each phase lasts.
- Flags illegal lamp combinations, out-of-order phase sequences and wrong phase durations.
- Sits beside the controller in the same clk1h domain; used on-board as a safety monitor and in simulation as a scoreboard.

Parameters:
- T_PH0, default 19: expected ticks in phase 0 (led1=100, led2=001).
- T_PH1, default 3: expected ticks in phase 1 (led1=100, led2=010).
- T_PH2, default 29: expected ticks in phase 2 (led1=001, led2=100).
- T_PH3, default 3: expected ticks in phase 3 (led1=010, led2=100).
- STUCK_LIMIT, default 40: tick count at which a held pattern counts as stuck (optional feature only).

Ports:
- clk1h  in  1  1 Hz system tick clock.
- rst_n  in  1  synchronous, active-low reset.
- led1  in  3  road-1 lamps {red, yellow, green}.
- led2  in  3  road-2 lamps {red, yellow, green}.
- err_clr  in  1  clears all sticky error flags.
- phase  out  2  decoded current phase (0..3).
- locked  out  1  monitor is in TRACK state.
- dur_cnt  out  6  ticks spent in the current pattern, saturates at 63.
- last_dur  out  6  duration of the most recently completed phase.
- cycle_cnt  out  8  completed phase-3→phase-0 cycles while locked; wraps 255→0.
- err_illegal  out  1  sticky: a non-legal pattern was sampled.
- err_order  out  1  sticky: a phase transition skipped or reversed the sequence.
- err_timing  out  1  sticky: a completed phase had the wrong duration.
- err_stuck  out  1  sticky: a pattern was held too long (optional feature).

Behaviour:
- Legal patterns, as {led1,led2}: 100_001=ph0, 100_010=ph1, 001_100=ph2, 010_100=ph3. Any other value is illegal.
- Inputs are sampled on every posedge clk1h. All outputs are registered, so an output reflects a pattern one edge after that pattern is sampled.
- Reset (rst_n=0 at an edge):
  - Outputs: phase=0, locked=0, dur_cnt=0, last_dur=0, cycle_cnt=0, all err_*=0.
  - Internal: state=SYNC, prev=NONE.
  - Reset asserted mid-phase discards the measurement in progress.
- Same pattern as prev: dur_cnt <= min(dur_cnt+1, 63).
- Legal pattern different from prev: last_dur <= dur_cnt, dur_cnt <= 1, phase <= new phase.
- State machine:
  - SYNC: first legal sample → ACQ, dur_cnt=1. No checks are made.
  - ACQ: the first phase may be partial, so no timing check. A transition to (phase+1) mod 4 → TRACK. Any other legal transition stays in ACQ.
  - TRACK: on every transition:
    - If new phase != (old phase+1) mod 4, set err_order.
    - If last_dur != T_PHold, set err_timing.
    - On a ph3→ph0 transition, increment cycle_cnt.
    - The state stays TRACK even when an error is set.
  - Any state, illegal sample: set err_illegal, state=SYNC, prev=NONE, dur_cnt=0, locked=0. phase holds its last value.
- locked = (state==TRACK).
- Sticky flags:
  - A flag clears only on reset or on err_clr=1 at an edge.
  - If err_clr and a new error condition occur in the same cycle, the error is set (set wins).
- Saturation: dur_cnt holding at 63 triggers a timing error on the next transition in TRACK, because 63 never equals a legal duration under the defaults.

Optional Feature:
- Macro: TRAFFIC_MON_STUCK_DETECT_EN.
- Defined:
  - In ACQ or TRACK, err_stuck is set when dur_cnt reaches STUCK_LIMIT on an unchanged pattern.
  - err_stuck is sticky and cleared like the other flags.
  - It does not change state.
- Undefined: the err_stuck port still exists, tied to 0. The STUCK_LIMIT comparison logic is not compiled.

Test Plan:
- Drive a correct 19/3/29/3 sequence for 3 full cycles after reset → locked=1 after the first ph0→ph1 edge, all err_*=0, last_dur takes 19, 3, 29, 3, cycle_cnt=2.
- While locked, hold ph2 for 28 ticks then go to ph3 → err_timing=1 one edge after the change, last_dur=28, locked stays 1.
- While locked, jump ph0→ph2 → err_order=1, phase=2. Then assert err_clr for one edge → err_order=0.
- While locked, apply led1=001, led2=001 → err_illegal=1, locked=0, dur_cnt=0. Resume legal ph1, then ph2 → locked=1 again with no err_timing.
- Assert err_clr on the same edge as a new order violation → err_order=1.
- With TRAFFIC_MON_STUCK_DETECT_EN defined, hold ph0 for 40 ticks → err_stuck=1, and dur_cnt saturates at 63 by tick 63. With the macro undefined, the same stimulus gives err_stuck=0.
